register_file: RTL and testbench

- Small architectural register file for the processor datapath: 8 registers of 8 bits each.
- One asynchronous (combinational) read port and one synchronous write port with an enable.
- Sits between the decode stage, which supplies the register IDs, and the ALU/writeback path, which supplies the write data.
- Synchronous active-low reset loads every register with a known value.

---
 rtl/register_file.sv | 26 ++
 tb/tb_register_file.sv | 122 ++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 8x8 architectural register file with combinational read,
// enabled synchronous write and synchronous active-low reset to reg[i]=i.
module register_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readRegId,
    input  logic [ADDR_W-1:0] writeRegId,
    input  logic [DATA_W-1:0] writeRegVal,
    input  logic              writeEnable,
    output logic [DATA_W-1:0] readVal
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk)
        for (int i = 0; i < NUM_REGS; i++)
            if (!reset)
                regs[i] <= DATA_W'(i);
            else if (writeEnable && writeRegId == ADDR_W'(i))
                regs[i] <= writeRegVal;

    assign readVal = regs[readRegId];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench; stimulus queues expected read values,
// a monitor compares them against readVal on each sample strobe.
module tb_register_file;
    logic       clk = 0;
    logic       reset = 0;
    logic [2:0] readRegId = 0;
    logic [2:0] writeRegId = 0;
    logic [7:0] writeRegVal = 0;
    logic       writeEnable = 0;
    logic [7:0] readVal;
    logic       sample = 0;

    typedef struct {
        string      n;
        logic [7:0] v;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model [8];
    int         passed = 0;
    int         total = 0;

    register_file dut (
        .clk(clk), .reset(reset), .readRegId(readRegId), .writeRegId(writeRegId),
        .writeRegVal(writeRegVal), .writeEnable(writeEnable), .readVal(readVal)
    );

    always #5 clk = ~clk;

    always @(posedge sample) begin
        exp_t e;
        total++;
        if (q.size() == 0)
            $display("FAIL scoreboard_empty: got %h with no expected value", readVal);
        else begin
            e = q.pop_front();
            if (readVal === e.v) passed++;
            else $display("FAIL %s: got %h expected %h", e.n, readVal, e.v);
        end
    end

    task automatic chk(input logic [2:0] id, input logic [7:0] v, input string n);
        readRegId = id;
        #1;
        q.push_back('{n, v});
        sample = 1;
        #1;
        sample = 0;
    endtask

    task automatic apply(input logic rst, input logic we, input logic [2:0] wid, input logic [7:0] wval);
        reset = rst;
        writeEnable = we;
        writeRegId = wid;
        writeRegVal = wval;
        @(posedge clk);
        if (!rst) for (int i = 0; i < 8; i++) model[i] = 8'(i);
        else if (we) model[wid] = wval;
        #2;
        reset = 1;
        writeEnable = 0;
    endtask

    initial begin
        logic [2:0] id, rid;
        logic [7:0] val;
        logic       we, rst;
        apply(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) chk(3'(i), 8'(i), "reset_val");

        apply(1, 1, 0, 8'hFF);
        chk(0, 8'hFF, "write_reg0");
        for (int i = 1; i < 8; i++) chk(3'(i), 8'(i), "write_others_hold");

        apply(1, 0, 3, 8'hFF);
        chk(3, 8'h03, "we0_reg3_hold");
        chk(0, 8'hFF, "we0_reg0_hold");

        readRegId = 5;
        writeEnable = 1;
        writeRegId = 5;
        writeRegVal = 8'hA5;
        chk(5, 8'h05, "rdw_before_edge");
        apply(1, 1, 5, 8'hA5);
        chk(5, 8'hA5, "rdw_after_edge");

        for (int i = 0; i < 8; i++) apply(1, 1, 3'(i), 8'hFF);
        for (int i = 0; i < 8; i++) chk(3'(i), 8'hFF, "fill_ff");
        apply(0, 1, 2, 8'h5A);
        for (int i = 0; i < 8; i++) chk(3'(i), 8'(i), "reset_beats_write");

        apply(1, 1, 6, 8'h3C);
        reset = 0;
        #2;
        reset = 1;
        for (int i = 0; i < 8; i++) chk(3'(i), model[i], "reset_no_clk");

        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 15) != 0);
            we  = 1'($urandom);
            id  = 3'($urandom);
            val = 8'($urandom);
            rid = 3'($urandom);
            reset = rst;
            writeEnable = we;
            writeRegId = id;
            writeRegVal = val;
            chk(rid, model[rid], "rand_pre_edge");
            apply(rst, we, id, val);
            chk(id, model[id], "rand_post_edge");
            chk(rid, model[rid], "rand_other");
        end

        #5;
        if (q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
